// File: rtl/mole_driver.sv
// Whack-a-mole output engine: LFSR hole pick, timed mole window, strike judging.
// Define MOLE_SPEEDUP_EN to shorten the lit window after every hit.
module mole_driver #(
  parameter int          NUM_HOLES      = 4,
  parameter int          LIT_CYCLES     = 50_000_000,
  parameter int          GAP_CYCLES     = 25_000_000,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5,
  parameter int          MIN_LIT_CYCLES = 12_500_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_HOLES-1:0]         hit_btn,
  output logic [NUM_HOLES-1:0]         mole_led,
  output logic [$clog2(NUM_HOLES)-1:0] hole_idx,
  output logic                         hit_pulse,
  output logic                         miss_pulse,
  output logic                         wrong_pulse,
  output logic                         busy
);

  // state | meaning
  // IDLE  | game stopped, all dark
  // GAP   | dark interval between moles, strikes ignored
  // SHOW  | one mole lit, strikes judged

  localparam int IDX_W   = $clog2(NUM_HOLES);
  localparam int CNT_MAX = (LIT_CYCLES > GAP_CYCLES) ? LIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LIT_LEN  = CNT_W'(LIT_CYCLES);
  localparam logic [CNT_W-1:0] MIN_LEN  = CNT_W'(MIN_LIT_CYCLES);

  if (!(NUM_HOLES == 2 || NUM_HOLES == 4 || NUM_HOLES == 8)) begin : g_bad_holes
    $error("mole_driver: NUM_HOLES must be 2, 4 or 8");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("mole_driver: LFSR_SEED must be non-zero");
  end
  if (MIN_LIT_CYCLES < 1 || MIN_LIT_CYCLES > LIT_CYCLES || GAP_CYCLES < 1) begin : g_bad_times
    $error("mole_driver: need 1 <= MIN_LIT_CYCLES <= LIT_CYCLES and GAP_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             lfsr_q;
  logic                   lfsr_fb;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_HOLES-1:0]   btn_q;
  logic [NUM_HOLES-1:0]   strike;
  logic [NUM_HOLES-1:0]   led_q, led_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   hit_q, hit_d, miss_q, miss_d, wrong_q, wrong_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       lit_len;

`ifdef MOLE_SPEEDUP_EN
  logic [CNT_W-1:0] lit_len_q, lit_len_d, lit_shrunk;
  assign lit_len    = lit_len_q;
  assign lit_shrunk = lit_len_q - (lit_len_q >> 3);
`else
  assign lit_len = LIT_LEN;
`endif

  // x^8+x^6+x^5+x^4+1; a non-zero seed can never reach the all-zero lockup.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign strike  = hit_btn & ~btn_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      lfsr_q    <= LFSR_SEED;
      cnt_q     <= '0;
      btn_q     <= '0;
      led_q     <= '0;
      idx_q     <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      wrong_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MOLE_SPEEDUP_EN
      lit_len_q <= LIT_LEN;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= {lfsr_q[6:0], lfsr_fb};
      cnt_q     <= cnt_d;
      btn_q     <= hit_btn;
      led_q     <= led_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      wrong_q   <= wrong_d;
      busy_q    <= busy_d;
`ifdef MOLE_SPEEDUP_EN
      lit_len_q <= lit_len_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    led_d   = led_q;
    idx_d   = idx_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    wrong_d = 1'b0;
    busy_d  = busy_q;
`ifdef MOLE_SPEEDUP_EN
    lit_len_d = lit_len_q;
`endif
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      led_d   = '0;
      busy_d  = 1'b0;
`ifdef MOLE_SPEEDUP_EN
      lit_len_d = LIT_LEN;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
          busy_d  = 1'b1;
        end
        GAP: begin
          if (cnt_q == '0) begin
            state_d = SHOW;
            idx_d   = lfsr_q[IDX_W-1:0];
            led_d   = NUM_HOLES'(1) << lfsr_q[IDX_W-1:0];
            cnt_d   = lit_len - 1'b1;
          end
        end
        SHOW: begin
          // Hit beats both a simultaneous wrong strike and window expiry.
          if (strike[idx_q]) begin
            hit_d   = 1'b1;
            led_d   = '0;
            state_d = GAP;
            cnt_d   = GAP_LOAD;
`ifdef MOLE_SPEEDUP_EN
            lit_len_d = (lit_shrunk < MIN_LEN) ? MIN_LEN : lit_shrunk;
`endif
          end else if (strike != '0) begin
            wrong_d = 1'b1;
          end else if (cnt_q == '0) begin
            miss_d  = 1'b1;
            led_d   = '0;
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end
        default: begin
          state_d = IDLE;
          led_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign mole_led    = led_q;
  assign hole_idx    = idx_q;
  assign hit_pulse   = hit_q;
  assign miss_pulse  = miss_q;
  assign wrong_pulse = wrong_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_mole_driver.sv
// Bench for mole_driver: reference LFSR model plus a queue of expected pulses.
module tb_mole_driver;
  localparam int         NH   = 4;
  localparam int         LIT  = 16;
  localparam int         GAP  = 8;
  localparam int         MINL = 10;
  localparam logic [7:0] SEED = 8'hA5;
  localparam logic [2:0] P_HIT = 3'b100, P_MISS = 3'b010, P_WRONG = 3'b001;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [NH-1:0] hit_btn = '0;
  logic [NH-1:0] mole_led;
  logic [1:0]    hole_idx;
  logic          hit_pulse, miss_pulse, wrong_pulse, busy;

  always #5 clk = ~clk;

  mole_driver #(
    .NUM_HOLES(NH), .LIT_CYCLES(LIT), .GAP_CYCLES(GAP),
    .LFSR_SEED(SEED), .MIN_LIT_CYCLES(MINL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .hit_btn(hit_btn),
    .mole_led(mole_led), .hole_idx(hole_idx), .hit_pulse(hit_pulse),
    .miss_pulse(miss_pulse), .wrong_pulse(wrong_pulse), .busy(busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference LFSR; lfsr_prev holds the value the DUT saw at the last edge.
  logic [7:0] lfsr_m = SEED;
  logic [7:0] lfsr_prev = SEED;
  always @(posedge clk) begin
    lfsr_prev = lfsr_m;
    if (!reset) lfsr_m = SEED;
    else        lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
  end

  logic [2:0] sb[$];
  logic [2:0] pcode;
  always @(negedge clk) begin
    if (reset) begin
      pcode = {hit_pulse, miss_pulse, wrong_pulse};
      if (pcode != 3'b000) begin
        if (sb.size() == 0) chk("unexpected_pulse", 32'(pcode), 32'd0);
        else                chk("pulse_kind", 32'(pcode), 32'(sb.pop_front()));
      end
    end
  end

  logic [1:0] exp_hole;
  int         exp_len;
  int         lit;
  int         tab[7];

  function automatic int next_len(input int l);
`ifdef MOLE_SPEEDUP_EN
    int n;
    n = l - (l >> 3);
    return (n < MINL) ? MINL : n;
`else
    return l;
`endif
  endfunction

  task automatic wait_led_on(input string tag);
    int g = 0;
    while (mole_led == '0 && g < 200) begin
      g++;
      @(negedge clk);
    end
    chk({tag, "_gap"}, 32'(g), 32'(GAP));
    exp_hole = lfsr_prev[1:0];
    chk({tag, "_hole"}, 32'(hole_idx), 32'(exp_hole));
    chk({tag, "_onehot"}, 32'(mole_led), 32'(NH'(1) << exp_hole));
  endtask

  // kind: 0 none, 1 correct, 2 wrong, 3 correct+wrong; driven on lit cycle 'at'.
  task automatic show_mole(input int kind, input int at, input bit hold, output int n_lit);
    logic [1:0] wh;
    wh = exp_hole + 2'd1;
    n_lit = 0;
    while (mole_led != '0 && n_lit < 200) begin
      n_lit++;
      if (n_lit == at) begin
        case (kind)
          1: hit_btn = NH'(1) << exp_hole;
          2: hit_btn = NH'(1) << wh;
          3: hit_btn = (NH'(1) << exp_hole) | (NH'(1) << wh);
          default: ;
        endcase
      end else if (n_lit == at + 1) begin
        if (kind == 2) chk("wrong_led_kept", 32'(mole_led), 32'(NH'(1) << exp_hole));
        if (!hold) hit_btn = '0;
      end
      @(negedge clk);
    end
    if (!hold) hit_btn = '0;
  endtask

  initial begin
`ifdef MOLE_SPEEDUP_EN
    tab = '{16, 14, 13, 12, 11, 10, 10};
`else
    tab = '{16, 16, 16, 16, 16, 16, 16};
`endif
    reset = 1'b0; enable = 1'b1; hit_btn = '0;
    repeat (3) @(negedge clk);
    chk("rst_led", 32'(mole_led), 32'd0);
    chk("rst_idx", 32'(hole_idx), 32'd0);
    chk("rst_pulses", 32'({hit_pulse, miss_pulse, wrong_pulse}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_busy", 32'(busy), 32'd1);
    chk("rel_led", 32'(mole_led), 32'd0);
    exp_len = LIT;

    for (int i = 0; i < 20; i++) begin
      wait_led_on("miss");
      sb.push_back(P_MISS);
      show_mole(0, 0, 1'b0, lit);
      chk("miss_lit", 32'(lit), 32'(exp_len));
    end

    wait_led_on("wrong");
    sb.push_back(P_WRONG);
    sb.push_back(P_MISS);
    show_mole(2, 5, 1'b0, lit);
    chk("wrong_lit", 32'(lit), 32'(exp_len));

    wait_led_on("both");
    sb.push_back(P_HIT);
    show_mole(3, 5, 1'b0, lit);
    chk("both_lit", 32'(lit), 32'd5);
    exp_len = next_len(exp_len);

    wait_led_on("last");
    sb.push_back(P_HIT);
    show_mole(1, exp_len, 1'b0, lit);
    chk("last_lit", 32'(lit), 32'(exp_len));
    exp_len = next_len(exp_len);

    wait_led_on("hit5");
    sb.push_back(P_HIT);
    show_mole(1, 5, 1'b1, lit);
    chk("hit5_lit", 32'(lit), 32'd5);
    exp_len = next_len(exp_len);
    wait_led_on("held1");
    sb.push_back(P_MISS);
    show_mole(0, 0, 1'b1, lit);
    chk("held1_lit", 32'(lit), 32'(exp_len));
    wait_led_on("held2");
    sb.push_back(P_MISS);
    show_mole(0, 7, 1'b0, lit);
    chk("held2_lit", 32'(lit), 32'(exp_len));
    #1 chk("sb_drained_a", 32'(sb.size()), 32'd0);

    wait_led_on("endrop");
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("endrop_led", 32'(mole_led), 32'd0);
    chk("endrop_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_busy", 32'(busy), 32'd1);
    exp_len = LIT;

    for (int k = 0; k < 7; k++) begin
      wait_led_on("speed");
      sb.push_back(P_HIT);
      show_mole(1, tab[k], 1'b0, lit);
      chk("speed_lit", 32'(lit), 32'(tab[k]));
    end

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst2_led", 32'(mole_led), 32'd0);
    chk("rst2_idx", 32'(hole_idx), 32'd0);
    chk("rst2_pulses", 32'({hit_pulse, miss_pulse, wrong_pulse}), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_rel_busy", 32'(busy), 32'd1);
    exp_len = LIT;
    wait_led_on("rst2");
    sb.push_back(P_MISS);
    show_mole(0, 0, 1'b0, lit);
    chk("rst2_lit", 32'(lit), 32'(exp_len));
    #1 chk("sb_drained_b", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mole_driver.md
Name: mole_driver

Overview:
- Output-side game engine for the whack-a-mole datapath.
- Picks a pseudo-random hole, lights its mole LED for a bounded window, and judges button presses against it.
- Hit buttons arrive already registered by the input flip-flop stage.
- Emits one-cycle hit/miss/wrong pulses to the score logic.

Parameters:
- NUM_HOLES, 4, number of holes/LEDs/buttons; must be 2, 4 or 8.
- LIT_CYCLES, 50_000_000, clock cycles a mole stays lit.
- GAP_CYCLES, 25_000_000, dark cycles between moles.
- LFSR_SEED, 8'hA5, LFSR reset value; must be non-zero.
- MIN_LIT_CYCLES, 12_500_000, floor on lit window; used only with SPEEDUP_EN.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset (reset==0 at posedge resets the block)
- enable  input  1  game running; 0 forces IDLE
- hit_btn  input  NUM_HOLES  registered button levels, 1 = pressed
- mole_led  output  NUM_HOLES  one-hot lit mole, all-zero when dark
- hole_idx  output  clog2(NUM_HOLES)  index of current/last mole
- hit_pulse  output  1  one cycle, correct hole struck
- miss_pulse  output  1  one cycle, lit window expired unstruck
- wrong_pulse  output  1  one cycle, non-lit hole struck while a mole is lit
- busy  output  1  1 in GAP or SHOW

Behaviour:
- All outputs are registered.
- Reset (reset==0 at posedge) has priority over everything:
  - state=IDLE; mole_led=0; hole_idx=0; all pulses=0; busy=0.
  - lfsr=LFSR_SEED; cnt=0; btn_q=0; lit_len=LIT_CYCLES.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts every non-reset cycle regardless of state.
  - Never reaches 0.
- Edge detect:
  - btn_q<=hit_btn every cycle.
  - strike[i] = hit_btn[i] & ~btn_q[i].
  - A held button never re-strikes.
  - A button already held when a mole appears does not count.
- Pulses default to 0 every cycle; each is high for exactly one cycle per event.
- FSM states: IDLE, GAP, SHOW.
- Any state with enable==0: next state IDLE, mole_led=0, no pulse issued. This includes mid-SHOW; no miss is reported.
- IDLE:
  - If enable==1: go to GAP, cnt=GAP_CYCLES-1, busy=1.
- GAP:
  - cnt decrements each cycle; strikes are ignored.
  - At cnt==0: go to SHOW.
  - hole_idx = lfsr[clog2(NUM_HOLES)-1:0].
  - mole_led = 1<<hole_idx.
  - cnt = lit_len-1.
- SHOW, evaluated in priority order each cycle:
  - a) strike[hole_idx]==1: hit_pulse=1, mole_led=0, go to GAP (cnt=GAP_CYCLES-1). Any simultaneous wrong strike is discarded.
  - b) Else any other strike bit: wrong_pulse=1, stay in SHOW, cnt keeps decrementing, LED stays lit.
  - c) Else cnt==0: miss_pulse=1, mole_led=0, go to GAP.
  - A hit on the same cycle as cnt==0 counts as a hit, not a miss.
- Timing and latency:
  - mole_led is lit for exactly lit_len cycles if unstruck.
  - Gap is exactly GAP_CYCLES cycles.
  - Strike sampled at posedge N: pulse and LED clear are visible after posedge N (1-cycle latency).
- Counter width is clog2(max(LIT_CYCLES,GAP_CYCLES)+1). Decrement never wraps below 0.
- The same hole may repeat on consecutive moles.

Optional Feature:
- Macro: MOLE_SPEEDUP_EN.
- Defined:
  - On each hit, lit_len <= lit_len - (lit_len>>3), saturating at MIN_LIT_CYCLES.
  - The new value applies from the next mole.
  - Misses and wrong strikes leave lit_len unchanged.
  - Reset or enable==0 restores lit_len=LIT_CYCLES.
- Undefined: lit_len is the constant LIT_CYCLES; MIN_LIT_CYCLES has no effect.

Test Plan:
- Bench parameters for all scenarios: NUM_HOLES=4, LIT_CYCLES=16, GAP_CYCLES=8, MIN_LIT_CYCLES=10, SEED=8'hA5.
- Hold reset=0 for 3 cycles with enable=1 -> all outputs 0, state IDLE. Release -> busy=1 next cycle; first mole_led one-hot after exactly 8 gap cycles; hole_idx matches a reference LFSR model.
- No presses -> mole_led lit exactly 16 cycles, then miss_pulse=1 for 1 cycle, LED 0, and the next mole 8 cycles later. Repeat 20 moles; every hole_idx matches the model.
- Press the correct button 5 cycles into SHOW -> hit_pulse=1 and mole_led=0 one cycle after the sampling edge; no miss_pulse. Hold the button 40 cycles -> no further pulses.
- Press a wrong button mid-SHOW -> wrong_pulse=1 once, LED unchanged, miss_pulse still at cycle 16. Correct and wrong strike in the same cycle -> hit_pulse only. Correct strike on the cnt==0 cycle -> hit_pulse, no miss_pulse.
- Drop enable mid-SHOW -> mole_led=0 and busy=0 next cycle, no pulses. Assert reset=0 mid-GAP -> full reset values, LFSR reseeds to A5.
- With MOLE_SPEEDUP_EN -> lit window across successive hits is 16, 14, 13, 12, 11, 10, 10 cycles. Without the macro -> always 16.
